// File: rtl/nn_loader_if.sv
// nn_loader_if: sample stream, frame bus and frame handshake for nn_frame_loader.
// The loader side uses the slave modport; the producer/consumer side uses master.
// N_IN and IN_W must match the parameters of the connected nn_frame_loader.
interface nn_loader_if #(
  parameter int N_IN = 80,
  parameter int IN_W = 6
);
  logic [IN_W-1:0]      s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 s_last;
  logic [N_IN*IN_W-1:0] frame;
  logic                 frame_valid;
  logic                 frame_ack;
  logic [6:0]           fill_cnt;

  modport master (
    output s_data, s_valid, s_last, frame_ack,
    input  s_ready, frame, frame_valid, fill_cnt
  );

  modport slave (
    input  s_data, s_valid, s_last, frame_ack,
    output s_ready, frame, frame_valid, fill_cnt
  );
endinterface

// File: rtl/nn_frame_loader.sv
// nn_frame_loader: collects N_IN feature samples into a flat frame register that
// feeds a combinational network, waits SETTLE_CYC cycles for it to settle, then
// holds the frame with frame_valid high until the consumer acknowledges.
// Optional feature: define NN_LOADER_PAD_EN to let s_last end a short frame,
// zero-filling the remaining slots. Without it s_last is ignored.
module nn_frame_loader #(
  parameter int N_IN       = 80,
  parameter int IN_W       = 6,
  parameter int SETTLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  nn_loader_if.slave  bus
);

  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [6:0] LAST_SLOT   = 7'(N_IN - 1);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);
`ifdef NN_LOADER_PAD_EN
  localparam logic [6:0] FULL_CNT    = 7'(N_IN);
`endif

  logic [1:0]           state_q, state_d;
  logic [6:0]           fill_cnt_q, fill_cnt_d;
  logic [3:0]           settle_q, settle_d;
  logic [N_IN*IN_W-1:0] frame_q, frame_d;
  logic                 s_ready_q, s_ready_d;
  logic                 xfer;

  // s_ready_q is low out of reset, so no transfer happens before the first edge.
  assign xfer = bus.s_valid && s_ready_q && (state_q == ST_FILL);

  // Next-state, slot write, fill counter and settle counter.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    settle_d   = settle_q;
    frame_d    = frame_q;
    case (state_q)
      ST_FILL: begin
        if (xfer) begin
          for (int k = 0; k < N_IN; k++) begin
            if (7'(k) == fill_cnt_q) frame_d[k*IN_W +: IN_W] = bus.s_data;
          end
          fill_cnt_d = fill_cnt_q + 7'd1;
          if (fill_cnt_q == LAST_SLOT) begin
            state_d  = ST_SETTLE;
            settle_d = SETTLE_LOAD;
          end
`ifdef NN_LOADER_PAD_EN
          else if (bus.s_last) begin
            // Short frame: every slot past the one just written becomes zero.
            for (int k = 0; k < N_IN; k++) begin
              if (7'(k) > fill_cnt_q) frame_d[k*IN_W +: IN_W] = '0;
            end
            fill_cnt_d = FULL_CNT;
            state_d    = ST_SETTLE;
            settle_d   = SETTLE_LOAD;
          end
`endif
        end
      end
      ST_SETTLE: begin
        if (settle_q == 4'd0) state_d = ST_HOLD;
        else                  settle_d = settle_q - 4'd1;
      end
      ST_HOLD: begin
        // Old frame contents stay until overwritten by the next fill.
        if (bus.frame_ack) begin
          state_d    = ST_FILL;
          fill_cnt_d = '0;
        end
      end
      default: state_d = ST_FILL;
    endcase
    // Registered from next state so s_ready never depends on s_valid.
    s_ready_d = (state_d == ST_FILL);
  end

  // State and frame registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      fill_cnt_q <= '0;
      settle_q   <= '0;
      frame_q    <= '0;
      s_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      settle_q   <= settle_d;
      frame_q    <= frame_d;
      s_ready_q  <= s_ready_d;
    end
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.frame       = frame_q;
  assign bus.frame_valid = (state_q == ST_HOLD);
  assign bus.fill_cnt    = fill_cnt_q;

endmodule

// File: doc/nn_frame_loader.md
NN_FRAME_LOADER -- requirements
Module: nn_frame_loader

Interface
REQ-001 Parameter N_IN, default 80, number of network input features per frame.
REQ-002 Parameter IN_W, default 6, unsigned width of each feature sample.
REQ-003 Parameter SETTLE_CYC, default 4, range 1..15, cycles allowed for the combinational network to settle after frame load.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_data  input  IN_W  incoming feature sample.
REQ-007 s_valid  input  1  s_data is valid this cycle.
REQ-008 s_ready  output  1  loader accepts a sample this cycle.
REQ-009 s_last  input  1  sample is the last of a short frame; used only when NN_LOADER_PAD_EN is defined.
REQ-010 frame  output  N_IN*IN_W  flat feature bus; bits [IN_W*k+IN_W-1 : IN_W*k] hold feature k+1.
REQ-011 frame_valid  output  1  frame is stable and settled; network outputs may be sampled.
REQ-012 frame_ack  input  1  consumer has sampled network outputs; release the frame.
REQ-013 fill_cnt  output  7  number of samples accepted into the current frame.

Function
REQ-014 The block SHALL implement three states: FILL, SETTLE and HOLD.
REQ-015 In FILL, s_ready SHALL be 1, and a transfer SHALL occur when s_valid and s_ready are both 1.
REQ-016 Each transfer SHALL write s_data into feature slot fill_cnt and then increment fill_cnt.
REQ-017 The transfer writing slot N_IN-1 SHALL move the block to SETTLE on the next edge.
- fill_cnt SHALL then hold N_IN.
REQ-018 On entering SETTLE, a down-counter SHALL load SETTLE_CYC-1.
- The block SHALL go to HOLD when the counter is 0; otherwise the counter SHALL decrement.
- frame_valid SHALL therefore rise exactly SETTLE_CYC cycles after the final transfer edge.
REQ-019 In SETTLE and HOLD, s_ready SHALL be 0, and frame contents SHALL NOT change.
REQ-020 In HOLD, frame_valid SHALL be 1, and frame_valid SHALL be 0 in every other state.
REQ-021 frame_ack sampled 1 in HOLD SHALL move the block to FILL on the next edge.
- On that edge, fill_cnt SHALL clear to 0.
- frame contents SHALL be retained until overwritten slot by slot.
REQ-022 frame_ack SHALL be ignored outside HOLD.
REQ-023 s_valid asserted outside FILL SHALL be ignored, with no write and no state change.
REQ-024 The frame_ack edge that leaves HOLD SHALL NOT accept a sample.
- The first sample of the next frame SHALL be accepted no earlier than the following cycle.
REQ-025 s_ready SHALL be a registered function of state only, with no combinational path from s_valid.

Reset
REQ-026 Asserting rst_n low SHALL immediately force the following, regardless of clk:
- state FILL;
- fill_cnt 0;
- settle counter 0;
- all frame bits 0;
- frame_valid 0.
REQ-027 s_ready SHALL be 0 while rst_n is low and SHALL be 1 from the first rising edge after deassertion.
REQ-028 Reset during SETTLE or HOLD SHALL discard the frame, and no frame_valid pulse SHALL follow.

Configuration
REQ-029 Macro NN_LOADER_PAD_EN defined: a transfer with s_last=1 and fill_cnt < N_IN-1 SHALL:
- write s_data;
- zero all remaining slots on the same edge;
- set fill_cnt to N_IN;
- enter SETTLE.
REQ-030 Macro NN_LOADER_PAD_EN undefined: s_last SHALL be ignored, and no zero-padding logic SHALL be synthesized.

Verification
REQ-031 Reset, then 80 back-to-back transfers with s_data=k mod 64 -> frame_valid rises 4 cycles after the 80th transfer, and slot k holds k mod 64.
REQ-032 In HOLD, drive s_valid=1 with data 6'h3F for 10 cycles -> s_ready=0, frame unchanged, frame_valid stays 1.
REQ-033 frame_ack pulse in HOLD -> next cycle frame_valid=0, s_ready=1, fill_cnt=0; second frame of 80 samples loads correctly.
REQ-034 Assert rst_n low after the 50th transfer, release, then send 80 samples -> no frame_valid before the 80th new transfer, and all slots are correct.
REQ-035 With NN_LOADER_PAD_EN defined, send 20 samples of 6'h15 with s_last on the 20th -> slots 0..19 = 6'h15, slots 20..79 = 0, frame_valid after 4 cycles.
REQ-036 With SETTLE_CYC=1 and random s_valid gaps -> frame_valid exactly 1 cycle after the final transfer, and no sample is lost or duplicated.
